// File: rtl/buscador_binario_if.sv
// ============================================================================
// Module      : buscador_binario_if
// Description : Handshake and comparator bundle for the binary-search
//               controller (start, comparator flags, guess and status).
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface buscador_binario_if #(
  parameter int N  = 4,
  parameter int PW = $clog2(N + 2)
) ();
  logic          inicio;
  logic          igual;
  logic          menor;
  logic          mayor;
  logic [N-1:0]  intento;
  logic          valido;
  logic          listo;
  logic          error;
  logic [N-1:0]  resultado;
  logic [PW-1:0] pasos;

  // The controller sits on the slave side; the comparator/host on the master side.
  modport slave (
    input  inicio, igual, menor, mayor,
    output intento, valido, listo, error, resultado, pasos
  );

  modport master (
    output inicio, igual, menor, mayor,
    input  intento, valido, listo, error, resultado, pasos
  );
endinterface

`default_nettype wire

// File: rtl/buscador_binario.sv
// ============================================================================
// Module      : buscador_binario
// Description : Sequential binary-search controller that drives a magnitude
//               comparator operand and converges on the hidden value.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module buscador_binario #(
  parameter int N  = 4,
  parameter int PW = $clog2(N + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  buscador_binario_if.slave io_bus
);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    EVALUAR = 2'd1,
    HECHO   = 2'd2,
    ERROR   = 2'd3
  } estado_t;

  localparam logic [N:0]   c_HI_INI      = {1'b0, {N{1'b1}}};
  localparam logic [N-1:0] c_INTENTO_INI = {1'b0, {(N-1){1'b1}}};

  estado_t       r_estado,    w_estado;
  logic [N:0]    r_lo,        w_lo;
  logic [N:0]    r_hi,        w_hi;
  logic [N-1:0]  r_intento,   w_intento;
  logic          r_valido,    w_valido;
  logic          r_listo,     w_listo;
  logic          r_error,     w_error;
  logic [N-1:0]  r_resultado, w_resultado;
  logic [PW-1:0] r_pasos,     w_pasos;

  logic [2:0]    w_flags;
  logic [N:0]    w_lo_sig;
  logic [N:0]    w_hi_sig;
  logic          w_arranque;

  // Bounds carry one extra bit so guess+1 / guess-1 never wrap.
  assign w_flags    = {io_bus.igual, io_bus.menor, io_bus.mayor};
  assign w_lo_sig   = {1'b0, r_intento} + {{N{1'b0}}, 1'b1};
  assign w_hi_sig   = {1'b0, r_intento} - {{N{1'b0}}, 1'b1};
  assign w_arranque = io_bus.inicio && (r_estado != EVALUAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado    <= OCIOSO;
      r_lo        <= '0;
      r_hi        <= c_HI_INI;
      r_intento   <= '0;
      r_valido    <= 1'b0;
      r_listo     <= 1'b0;
      r_error     <= 1'b0;
      r_resultado <= '0;
      r_pasos     <= '0;
    end else begin
      r_estado    <= w_estado;
      r_lo        <= w_lo;
      r_hi        <= w_hi;
      r_intento   <= w_intento;
      r_valido    <= w_valido;
      r_listo     <= w_listo;
      r_error     <= w_error;
      r_resultado <= w_resultado;
      r_pasos     <= w_pasos;
    end
  end

  always_comb begin
    w_estado    = r_estado;
    w_lo        = r_lo;
    w_hi        = r_hi;
    w_intento   = r_intento;
    w_valido    = r_valido;
    w_listo     = r_listo;
    w_error     = r_error;
    w_resultado = r_resultado;
    w_pasos     = r_pasos;

    case (r_estado)
      EVALUAR: begin
        w_pasos = r_pasos + {{(PW-1){1'b0}}, 1'b1};
        if (!$onehot(w_flags)) begin
          w_estado = ERROR;
          w_error  = 1'b1;
          w_valido = 1'b0;
        end else if (io_bus.igual) begin
          w_estado    = HECHO;
          w_resultado = r_intento;
          w_listo     = 1'b1;
          w_valido    = 1'b0;
        end else if (io_bus.mayor) begin
          if (w_lo_sig > r_hi) begin
            w_estado = ERROR;
            w_error  = 1'b1;
            w_valido = 1'b0;
          end else begin
            w_lo      = w_lo_sig;
            w_intento = N'((w_lo_sig + r_hi) >> 1);
          end
        end else begin
          // Guess 0 underflows to -1 here, which the signed compare rejects.
          if ($signed(w_hi_sig) < $signed(r_lo)) begin
            w_estado = ERROR;
            w_error  = 1'b1;
            w_valido = 1'b0;
          end else begin
            w_hi      = w_hi_sig;
            w_intento = N'((r_lo + w_hi_sig) >> 1);
          end
        end
      end
      default: begin
        if (w_arranque) begin
          w_estado  = EVALUAR;
          w_lo      = '0;
          w_hi      = c_HI_INI;
          w_intento = c_INTENTO_INI;
          w_pasos   = '0;
          w_valido  = 1'b1;
          w_listo   = 1'b0;
          w_error   = 1'b0;
        end
      end
    endcase
  end

  assign io_bus.intento   = r_intento;
  assign io_bus.valido    = r_valido;
  assign io_bus.listo     = r_listo;
  assign io_bus.error     = r_error;
  assign io_bus.resultado = r_resultado;
  assign io_bus.pasos     = r_pasos;

endmodule

`default_nettype wire

// File: tb/tb_buscador_binario.sv
// Testbench for buscador_binario: comparator model plus a plain binary-search
// reference that predicts each guess, the final result and the step count.
`default_nettype none

module tb_buscador_binario;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  buscador_binario_if #(.N(N)) bus ();

  buscador_binario #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus.slave)
  );

  int         oculto = 0;
  bit         forzado = 1'b0;
  logic [2:0] forz = 3'b000;   // {igual, menor, mayor}

  assign bus.igual = forzado ? forz[2] : (oculto == int'(bus.intento));
  assign bus.menor = forzado ? forz[1] : (oculto <  int'(bus.intento));
  assign bus.mayor = forzado ? forz[0] : (oculto >  int'(bus.intento));

  int errores = 0;
  int checks  = 0;
  int q_esp[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    assert (obs === esp) else begin
      errores++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, esp);
    end
  endtask

  // Textbook binary search over 0..2^N-1 on integers.
  task automatic modelo(input int h);
    int lo, hi, mid;
    q_esp.delete();
    lo = 0;
    hi = (1 << N) - 1;
    while (lo <= hi) begin
      mid = (lo + hi) / 2;
      q_esp.push_back(mid);
      if (h == mid) break;
      if (h > mid) lo = mid + 1;
      else         hi = mid - 1;
    end
  endtask

  task automatic arrancar();
    bus.inicio = 1'b1;
    @(posedge clk); #1;
    bus.inicio = 1'b0;
  endtask

  // Follows the predicted guesses; ends one sample after the last evaluated edge.
  task automatic seguir(input string tag);
    foreach (q_esp[k]) begin
      chk({tag, "_intento"}, 32'(bus.intento), 32'(q_esp[k]));
      chk({tag, "_valido"},  32'(bus.valido), 32'd1);
      @(posedge clk); #1;
    end
  endtask

  task automatic buscar(input string tag, input int h);
    oculto  = h;
    forzado = 1'b0;
    modelo(h);
    arrancar();
    seguir(tag);
    chk({tag, "_listo"},     32'(bus.listo), 32'd1);
    chk({tag, "_error"},     32'(bus.error), 32'd0);
    chk({tag, "_valido_fin"}, 32'(bus.valido), 32'd0);
    chk({tag, "_resultado"}, 32'(bus.resultado), 32'(h));
    chk({tag, "_pasos"},     32'(bus.pasos), 32'(q_esp.size()));
  endtask

  initial begin
    bus.inicio = 1'b0;
    #12;
    chk("rst_intento", 32'(bus.intento), 32'd0);
    chk("rst_valido",  32'(bus.valido), 32'd0);
    chk("rst_listo",   32'(bus.listo), 32'd0);
    chk("rst_error",   32'(bus.error), 32'd0);
    chk("rst_res",     32'(bus.resultado), 32'd0);
    chk("rst_pasos",   32'(bus.pasos), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    buscar("h7", 7);
    buscar("h0", 0);
    buscar("h15", 15);
    buscar("h10", 10);

    // Restart straight from the finished state.
    arrancar();
    chk("rearr_listo",   32'(bus.listo), 32'd0);
    chk("rearr_intento", 32'(bus.intento), 32'd7);
    chk("rearr_valido",  32'(bus.valido), 32'd1);
    modelo(10);
    q_esp.delete(0);
    @(posedge clk); #1;
    seguir("rearr");
    chk("rearr_res",   32'(bus.resultado), 32'd10);
    chk("rearr_pasos", 32'(bus.pasos), 32'd4);

    // No flag on the first comparison.
    forzado = 1'b1;
    forz    = 3'b000;
    arrancar();
    chk("f000_intento", 32'(bus.intento), 32'd7);
    @(posedge clk); #1;
    chk("f000_error",  32'(bus.error), 32'd1);
    chk("f000_listo",  32'(bus.listo), 32'd0);
    chk("f000_pasos",  32'(bus.pasos), 32'd1);
    chk("f000_valido", 32'(bus.valido), 32'd0);

    // Two flags at once, restarting out of the error state.
    forz = 3'b110;
    arrancar();
    chk("f110_error_clr", 32'(bus.error), 32'd0);
    chk("f110_valido",    32'(bus.valido), 32'd1);
    @(posedge clk); #1;
    chk("f110_error", 32'(bus.error), 32'd1);
    chk("f110_pasos", 32'(bus.pasos), 32'd1);

    // mayor stuck high walks to the top of the range and then runs out.
    forz = 3'b001;
    modelo((1 << N) - 1);
    arrancar();
    seguir("stuck");
    chk("stuck_error", 32'(bus.error), 32'd1);
    chk("stuck_listo", 32'(bus.listo), 32'd0);
    chk("stuck_pasos", 32'(bus.pasos), 32'(N + 1));
    forzado = 1'b0;

    // Asynchronous reset during the third comparison.
    oculto = 0;
    arrancar();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ar_intento_pre", 32'(bus.intento), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_intento", 32'(bus.intento), 32'd0);
    chk("ar_valido",  32'(bus.valido), 32'd0);
    chk("ar_listo",   32'(bus.listo), 32'd0);
    chk("ar_error",   32'(bus.error), 32'd0);
    chk("ar_res",     32'(bus.resultado), 32'd0);
    chk("ar_pasos",   32'(bus.pasos), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ar_idle_valido", 32'(bus.valido), 32'd0);
    buscar("ar_h0", 0);

    // Random hidden values against the reference search.
    for (int i = 0; i < 24; i++) begin
      buscar("rnd", int'($urandom_range(0, (1 << N) - 1)));
    end

    $display("Result: errors=%0d of %0d checks", errores, checks);
    $finish;
  end

endmodule

`default_nettype wire
